// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcode constants, datapath select codes and the packed control word.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALUOp matches the ALU-control decoder encoding
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       instr_retired;
        logic       halted;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_out_decode.sv
// Purely combinational Moore output map: FSM state (plus mem_ready in the
// two handshake states) to the datapath control word.
import multicycle_control_pkg::*;

module mc_out_decode (
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = ctrl_idle();
        unique case (i_state)
            S_FETCH: begin
                o_ctrl.adr_src    = 1'b0;
                o_ctrl.alu_src_a  = SRCA_PC;
                o_ctrl.alu_src_b  = SRCB_FOUR;
                o_ctrl.alu_op     = ALUOP_ADD;
                o_ctrl.result_src = RES_ALURES;
                o_ctrl.ir_write   = i_mem_ready;
                o_ctrl.pc_update  = i_mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target from oldPC + imm
                o_ctrl.alu_src_a = SRCA_OLDPC;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                o_ctrl.result_src    = RES_MEMDATA;
                o_ctrl.reg_write     = 1'b1;
                o_ctrl.instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl.adr_src       = 1'b1;
                o_ctrl.result_src    = RES_ALUOUT;
                o_ctrl.mem_write     = 1'b1;
                o_ctrl.instr_retired = i_mem_ready;
            end
            S_EXECR: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_RS2;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.result_src    = RES_ALUOUT;
                o_ctrl.reg_write     = 1'b1;
                o_ctrl.instr_retired = 1'b1;
            end
            S_BEQ: begin
                o_ctrl.alu_src_a     = SRCA_RS1;
                o_ctrl.alu_src_b     = SRCB_RS2;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.result_src    = RES_ALUOUT;
                o_ctrl.branch        = 1'b1;
                o_ctrl.instr_retired = 1'b1;
            end
            S_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: begin
                o_ctrl = ctrl_idle();
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: state register, latched opcode
// and next-state logic; outputs come from mc_out_decode.
import multicycle_control_pkg::*;

module multicycle_control #(
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       instr_retired,
    output logic       halted
);

    localparam state_t ILLEGAL_NEXT = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;

    state_t     r_state;
    state_t     w_state_next;
    logic [6:0] r_opcode;
    state_t     w_dec_state;
    logic       w_dec_ready;
    ctrl_t      w_ctrl;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_FETCH:    w_state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
                    OP_RTYPE:          w_state_next = S_EXECR;
                    OP_ITYPE:          w_state_next = S_EXECI;
                    OP_BEQ:            w_state_next = S_BEQ;
                    default:           w_state_next = ILLEGAL_NEXT;
                endcase
            end
            // Only loads and stores reach MEMADR, so anything but a load is a store
            S_MEMADR:   w_state_next = (r_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_state_next = S_FETCH;
            S_MEMWRITE: w_state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_state_next = S_ALUWB;
            S_EXECI:    w_state_next = S_ALUWB;
            S_ALUWB:    w_state_next = S_FETCH;
            S_BEQ:      w_state_next = S_FETCH;
            S_HALT:     w_state_next = S_HALT;
            default:    w_state_next = S_FETCH;
        endcase
    end

    // While reset is asserted present the quiescent FETCH decode regardless of
    // the (possibly stale) state register, with the memory handshake masked.
    assign w_dec_state = reset_n ? r_state : S_FETCH;
    assign w_dec_ready = mem_ready & reset_n;

    mc_out_decode u_out_decode (
        .i_state     (w_dec_state),
        .i_mem_ready (w_dec_ready),
        .o_ctrl      (w_ctrl)
    );

    assign ALUOp         = w_ctrl.alu_op;
    assign ALUSrcA       = w_ctrl.alu_src_a;
    assign ALUSrcB       = w_ctrl.alu_src_b;
    assign ResultSrc     = w_ctrl.result_src;
    assign AdrSrc        = w_ctrl.adr_src;
    assign IRWrite       = w_ctrl.ir_write;
    assign PCUpdate      = w_ctrl.pc_update;
    assign Branch        = w_ctrl.branch;
    assign RegWrite      = w_ctrl.reg_write;
    assign MemWrite      = w_ctrl.mem_write;
    assign instr_retired = w_ctrl.instr_retired;
    assign halted        = w_ctrl.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: two controllers (illegal opcode -> HALT and -> FETCH) run
// the same directed instruction stream; per-cycle expected outputs are queued.
module tb_multicycle_control;

    // Vector order: ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
    // PCUpdate, Branch, RegWrite, MemWrite, instr_retired, halted
    localparam logic [15:0] F_R  = 16'b00_00_10_10_0_1_1_0_0_0_0_0;
    localparam logic [15:0] F_NR = 16'b00_00_10_10_0_0_0_0_0_0_0_0;
    localparam logic [15:0] DEC  = 16'b00_01_01_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] MADR = 16'b00_10_01_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] MRD  = 16'b00_00_00_00_1_0_0_0_0_0_0_0;
    localparam logic [15:0] MWB  = 16'b00_00_00_01_0_0_0_0_1_0_1_0;
    localparam logic [15:0] MW0  = 16'b00_00_00_00_1_0_0_0_0_1_0_0;
    localparam logic [15:0] MW1  = 16'b00_00_00_00_1_0_0_0_0_1_1_0;
    localparam logic [15:0] EXR  = 16'b10_10_00_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] EXI  = 16'b10_10_01_00_0_0_0_0_0_0_0_0;
    localparam logic [15:0] AWB  = 16'b00_00_00_00_0_0_0_0_1_0_1_0;
    localparam logic [15:0] BQ   = 16'b01_10_00_00_0_0_0_1_0_0_1_0;
    localparam logic [15:0] HLT  = 16'b00_00_00_00_0_0_0_0_0_0_0_1;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011;
    localparam logic [6:0] BE = 7'b1100011;
    localparam logic [6:0] IL = 7'b1111111;

    typedef struct {
        logic [15:0] e_halt;
        logic [15:0] e_fetch;
        string       nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] opcode;
    logic       mem_ready;

    logic [1:0] alu_op_h, src_a_h, src_b_h, res_h;
    logic       adr_h, irw_h, pcu_h, br_h, rw_h, mw_h, ret_h, hlt_h;
    logic [1:0] alu_op_f, src_a_f, src_b_f, res_f;
    logic       adr_f, irw_f, pcu_f, br_f, rw_f, mw_f, ret_f, hlt_f;
    logic [15:0] vec_h, vec_f;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_HALT(1)) u_dut_halt (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .ALUOp(alu_op_h), .ALUSrcA(src_a_h), .ALUSrcB(src_b_h), .ResultSrc(res_h),
        .AdrSrc(adr_h), .IRWrite(irw_h), .PCUpdate(pcu_h), .Branch(br_h),
        .RegWrite(rw_h), .MemWrite(mw_h), .instr_retired(ret_h), .halted(hlt_h)
    );

    multicycle_control #(.ILLEGAL_HALT(0)) u_dut_fetch (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .ALUOp(alu_op_f), .ALUSrcA(src_a_f), .ALUSrcB(src_b_f), .ResultSrc(res_f),
        .AdrSrc(adr_f), .IRWrite(irw_f), .PCUpdate(pcu_f), .Branch(br_f),
        .RegWrite(rw_f), .MemWrite(mw_f), .instr_retired(ret_f), .halted(hlt_f)
    );

    assign vec_h = {alu_op_h, src_a_h, src_b_h, res_h, adr_h, irw_h, pcu_h,
                    br_h, rw_h, mw_h, ret_h, hlt_h};
    assign vec_f = {alu_op_f, src_a_f, src_b_f, res_f, adr_f, irw_f, pcu_f,
                    br_f, rw_f, mw_f, ret_f, hlt_f};

    // One cycle of stimulus: drive just after the edge, queue what both DUTs
    // must present for the rest of this cycle.
    task automatic step(input logic rst_n, input logic [6:0] op, input logic rdy,
                        input logic [15:0] eh, input logic [15:0] ef, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = rst_n;
        opcode    = op;
        mem_ready = rdy;
        e.e_halt  = eh;
        e.e_fetch = ef;
        e.nm      = nm;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 2;
            if (vec_h !== e.e_halt) begin
                failures++;
                $display("FAIL %s halt_dut: got %b want %b", e.nm, vec_h, e.e_halt);
            end
            if (vec_f !== e.e_fetch) begin
                failures++;
                $display("FAIL %s fetch_dut: got %b want %b", e.nm, vec_f, e.e_fetch);
            end
            $display("[%0t] %s halt_dut=%b fetch_dut=%b", $time, e.nm, vec_h, vec_f);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b1;

        step(0, 7'd0, 1, F_NR, F_NR, "reset0");
        step(0, LD,   1, F_NR, F_NR, "reset1");

        // load, no memory wait; live opcode changes after DECODE
        step(1, 7'd0, 1, F_R,  F_R,  "ld_fetch");
        step(1, LD,   1, DEC,  DEC,  "ld_decode");
        step(1, RT,   1, MADR, MADR, "ld_memadr");
        step(1, RT,   1, MRD,  MRD,  "ld_memread");
        step(1, RT,   1, MWB,  MWB,  "ld_memwb");

        // store with one fetch wait and three write waits; live opcode is a load
        step(1, 7'd0, 0, F_NR, F_NR, "st_fetch_wait");
        step(1, 7'd0, 1, F_R,  F_R,  "st_fetch");
        step(1, ST,   1, DEC,  DEC,  "st_decode");
        step(1, LD,   0, MADR, MADR, "st_memadr");
        for (int i = 0; i < 3; i++) step(1, LD, 0, MW0, MW0, "st_write_wait");
        step(1, LD,   1, MW1,  MW1,  "st_write_done");

        // R-type then I-type
        step(1, 7'd0, 1, F_R,  F_R,  "r_fetch");
        step(1, RT,   1, DEC,  DEC,  "r_decode");
        step(1, RT,   1, EXR,  EXR,  "r_execr");
        step(1, RT,   1, AWB,  AWB,  "r_aluwb");
        step(1, 7'd0, 1, F_R,  F_R,  "i_fetch");
        step(1, IT,   1, DEC,  DEC,  "i_decode");
        step(1, IT,   1, EXI,  EXI,  "i_execi");
        step(1, IT,   1, AWB,  AWB,  "i_aluwb");

        // beq
        step(1, 7'd0, 1, F_R,  F_R,  "b_fetch");
        step(1, BE,   1, DEC,  DEC,  "b_decode");
        step(1, BE,   1, BQ,   BQ,   "b_beq");

        // load with two read waits
        step(1, 7'd0, 1, F_R,  F_R,  "ldw_fetch");
        step(1, LD,   1, DEC,  DEC,  "ldw_decode");
        step(1, ST,   1, MADR, MADR, "ldw_memadr");
        step(1, ST,   0, MRD,  MRD,  "ldw_read_wait");
        step(1, ST,   0, MRD,  MRD,  "ldw_read_wait");
        step(1, ST,   1, MRD,  MRD,  "ldw_read_done");
        step(1, ST,   1, MWB,  MWB,  "ldw_memwb");

        // reset asserted while in MEMREAD with the opcode changing
        step(1, 7'd0, 1, F_R,  F_R,  "rst_fetch");
        step(1, LD,   1, DEC,  DEC,  "rst_decode");
        step(1, LD,   1, MADR, MADR, "rst_memadr");
        step(1, LD,   0, MRD,  MRD,  "rst_memread");
        step(0, ST,   1, F_NR, F_NR, "rst_asserted");
        step(1, BE,   0, F_NR, F_NR, "post_rst_fetch");
        step(1, 7'd0, 1, F_R,  F_R,  "post_rst_fetch_go");
        step(1, RT,   1, DEC,  DEC,  "post_rst_decode");
        step(1, RT,   1, EXR,  EXR,  "post_rst_execr");
        step(1, RT,   1, AWB,  AWB,  "post_rst_aluwb");

        // illegal opcode: one DUT halts, the other returns to FETCH (ready held low)
        step(1, 7'd0, 1, F_R,  F_R,  "ill_fetch");
        step(1, IL,   1, DEC,  DEC,  "ill_decode");
        for (int i = 0; i < 20; i++) begin
            logic [6:0] op_v;
            op_v = (i % 2 == 0) ? LD : BE;
            step(1, op_v, 0, HLT, F_NR, "ill_halt_hold");
        end

        // reset out of HALT, then a beq runs normally
        step(0, 7'd0, 1, F_NR, F_NR, "halt_reset");
        step(1, 7'd0, 1, F_R,  F_R,  "hb_fetch");
        step(1, BE,   1, DEC,  DEC,  "hb_decode");
        step(1, BE,   1, BQ,   BQ,   "hb_beq");
        step(1, 7'd0, 0, F_NR, F_NR, "end_fetch");

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
